// File: rtl/compare_recoded_float_pipe.sv
// Two-stage pipelined comparator for recoded floating-point operands.
// Handles EQ/LT/LE/UNORD as boolean results and MIN/MAX as value results.
// Carries an opaque tag alongside each operation and keeps sticky invalid flags.
module compare_recoded_float_pipe #(
    parameter int expSize = 8,
    parameter int sigSize = 24,
    parameter int TAG_W   = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [expSize+sigSize:0]     in_a,
    input  logic [expSize+sigSize:0]     in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [expSize+sigSize:0]     out_result,
    output logic [4:0]                   out_flags,
    output logic [TAG_W-1:0]             out_tag,
    output logic [4:0]                   flags_acc,
    input  logic                         flags_clear
);

    localparam int size = expSize + sigSize;

    localparam logic [2:0] OP_EQ    = 3'd0;
    localparam logic [2:0] OP_LT    = 3'd1;
    localparam logic [2:0] OP_LE    = 3'd2;
    localparam logic [2:0] OP_MIN   = 3'd3;
    localparam logic [2:0] OP_MAX   = 3'd4;
    localparam logic [2:0] OP_UNORD = 3'd5;

    // Quiet NaN with positive sign and only the fraction MSB set.
    localparam logic [size:0] CANON_NAN =
        {1'b0, 3'b111, {(expSize-2){1'b0}}, 1'b1, {(sigSize-2){1'b0}}};

    // Stage 1 state: operands, decoded classes and the magnitude comparison.
    logic                s1Valid_q;
    logic [2:0]          s1Op_q;
    logic [TAG_W-1:0]    s1Tag_q;
    logic [size:0]       s1A_q;
    logic [size:0]       s1B_q;
    logic                s1NanA_q;
    logic                s1NanB_q;
    logic                s1SnanAny_q;
    logic                s1BothZero_q;
    logic                s1MagLt_q;
    logic                s1MagEq_q;

    // Stage 2 state: the final result as presented on the outputs.
    logic                s2Valid_q;
    logic [size:0]       s2Result_q;
    logic [4:0]          s2Flags_q;
    logic [TAG_W-1:0]    s2Tag_q;
    logic [4:0]          acc_q;

    // Decode of the incoming operands.
    logic                nanA_d;
    logic                nanB_d;
    logic                zeroA_d;
    logic                zeroB_d;
    logic                snanA_d;
    logic                snanB_d;
    logic [size-1:0]     magA_d;
    logic [size-1:0]     magB_d;

    // Stage 2 next-state values.
    logic [size:0]       result_d;
    logic                invalid_d;

    logic                s2Load;
    logic                outFire;

    assign s2Load   = !s2Valid_q || out_ready;
    assign in_ready = !s1Valid_q || s2Load;
    assign outFire  = s2Valid_q && out_ready;

    assign out_valid  = s2Valid_q;
    assign out_result = s2Result_q;
    assign out_flags  = s2Flags_q;
    assign out_tag    = s2Tag_q;
    assign flags_acc  = acc_q;

    // Classify both operands; zeros collapse to magnitude 0 so any zero encoding compares equal.
    always_comb begin
        nanA_d  = (in_a[size-1 -: 3] == 3'b111);
        nanB_d  = (in_b[size-1 -: 3] == 3'b111);
        zeroA_d = (in_a[size-1 -: 3] == 3'b000);
        zeroB_d = (in_b[size-1 -: 3] == 3'b000);
        snanA_d = nanA_d && !in_a[sigSize-2];
        snanB_d = nanB_d && !in_b[sigSize-2];
        magA_d  = zeroA_d ? '0 : in_a[size-1:0];
        magB_d  = zeroB_d ? '0 : in_b[size-1:0];
    end

    // Stage 1 captures a new operation whenever the pipe can move forward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid_q    <= 1'b0;
            s1Op_q       <= '0;
            s1Tag_q      <= '0;
            s1A_q        <= '0;
            s1B_q        <= '0;
            s1NanA_q     <= 1'b0;
            s1NanB_q     <= 1'b0;
            s1SnanAny_q  <= 1'b0;
            s1BothZero_q <= 1'b0;
            s1MagLt_q    <= 1'b0;
            s1MagEq_q    <= 1'b0;
        end else if (in_ready) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Op_q       <= in_op;
                s1Tag_q      <= in_tag;
                s1A_q        <= in_a;
                s1B_q        <= in_b;
                s1NanA_q     <= nanA_d;
                s1NanB_q     <= nanB_d;
                s1SnanAny_q  <= snanA_d || snanB_d;
                s1BothZero_q <= zeroA_d && zeroB_d;
                s1MagLt_q    <= (magA_d < magB_d);
                s1MagEq_q    <= (magA_d == magB_d);
            end
        end
    end

    // Resolve the selected operation from the stage 1 decode into a result and invalid bit.
    always_comb begin
        logic signA;
        logic signB;
        logic unord;
        logic eqR;
        logic ltR;
        logic gtR;
        logic aLessTot;
        logic bLessTot;
        logic magGt;

        signA = s1A_q[size];
        signB = s1B_q[size];
        unord = s1NanA_q || s1NanB_q;
        magGt = !s1MagLt_q && !s1MagEq_q;

        eqR = !unord && (s1BothZero_q || ((signA == signB) && s1MagEq_q));
        ltR = !unord && !s1BothZero_q &&
              ((signA && !signB) || (!signA && !signB && s1MagLt_q) || (signA && signB && magGt));
        gtR = !unord && !s1BothZero_q &&
              ((!signA && signB) || (!signA && !signB && magGt) || (signA && signB && s1MagLt_q));

        // For MIN/MAX a negative zero sorts below a positive zero.
        aLessTot = ltR || (s1BothZero_q && signA && !signB);
        bLessTot = gtR || (s1BothZero_q && !signA && signB);

        result_d  = '0;
        invalid_d = 1'b0;

        case (s1Op_q)
            OP_EQ: begin
                result_d[0] = eqR;
                invalid_d   = s1SnanAny_q;
            end
            OP_LT: begin
                result_d[0] = ltR;
                invalid_d   = unord;
            end
            OP_LE: begin
                result_d[0] = ltR || eqR;
                invalid_d   = unord;
            end
            OP_UNORD: begin
                result_d[0] = unord;
                invalid_d   = s1SnanAny_q;
            end
            OP_MIN, OP_MAX: begin
                invalid_d = s1SnanAny_q;
                if (s1NanA_q && s1NanB_q) begin
                    result_d = CANON_NAN;
                end else if (s1NanA_q) begin
                    result_d = s1B_q;
                end else if (s1NanB_q) begin
                    result_d = s1A_q;
                end else if (s1Op_q == OP_MIN) begin
                    result_d = bLessTot ? s1B_q : s1A_q;
                end else begin
                    result_d = aLessTot ? s1B_q : s1A_q;
                end
            end
            default: begin
                result_d  = '0;
                invalid_d = 1'b1;
            end
        endcase
    end

    // Stage 2 registers the result; it holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2Valid_q  <= 1'b0;
            s2Result_q <= '0;
            s2Flags_q  <= '0;
            s2Tag_q    <= '0;
        end else if (s2Load) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Result_q <= result_d;
                s2Flags_q  <= {invalid_d, 4'b0000};
                s2Tag_q    <= s1Tag_q;
            end
        end
    end

    // Sticky flag accumulator; a clear drops history but keeps the flags handed over this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (flags_clear) begin
            acc_q <= outFire ? s2Flags_q : 5'b00000;
        end else if (outFire) begin
            acc_q <= acc_q | s2Flags_q;
        end
    end

endmodule

// File: tb/tb_compare_recoded_float_pipe.sv
// Self-checking bench for compare_recoded_float_pipe.
// Directed and random operations feed a scoreboard queue; a negedge monitor pops and compares.
module tb_compare_recoded_float_pipe;

    localparam int EXP = 8;
    localparam int SIG = 24;
    localparam int TW  = 5;
    localparam int W   = EXP + SIG + 1;

    localparam logic [2:0] OP_EQ    = 3'd0;
    localparam logic [2:0] OP_LT    = 3'd1;
    localparam logic [2:0] OP_LE    = 3'd2;
    localparam logic [2:0] OP_MIN   = 3'd3;
    localparam logic [2:0] OP_MAX   = 3'd4;
    localparam logic [2:0] OP_UNORD = 3'd5;

    localparam logic [W-1:0] POS_ZERO = 33'h000000000;
    localparam logic [W-1:0] NEG_ZERO = 33'h100000000;
    localparam logic [W-1:0] ONE      = 33'h080000000;
    localparam logic [W-1:0] TWO      = 33'h080800000;
    localparam logic [W-1:0] NEG_ONE  = 33'h180000000;
    localparam logic [W-1:0] NEG_TWO  = 33'h180800000;
    localparam logic [W-1:0] QNAN     = 33'h0E0400000;
    localparam logic [W-1:0] SNAN     = 33'h0E0000001;
    localparam logic [W-1:0] SNAN_NEG = 33'h1E0000005;
    localparam logic [W-1:0] CANON    = 33'h0E0400000;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [4:0]    flags;
        logic [TW-1:0] tag;
    } ExpEntry;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_op;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [TW-1:0]  in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic [4:0]     out_flags;
    logic [TW-1:0]  out_tag;
    logic [4:0]     flags_acc;
    logic           flags_clear;

    ExpEntry        sbQueue[$];
    int             hsCycles[$];
    int             compared = 0;
    int             mismatched = 0;
    int             cyc = 0;

    logic [4:0]     accExp;
    logic           prevHeld;
    logic [W-1:0]   prevRes;
    logic [4:0]     prevFlags;
    logic [TW-1:0]  prevTag;
    logic [4:0]     hsFlags;
    ExpEntry        popped;

    compare_recoded_float_pipe #(.expSize(EXP), .sigSize(SIG), .TAG_W(TW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_tag     (out_tag),
        .flags_acc   (flags_acc),
        .flags_clear (flags_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Reference model: ordinal keys on signed integers, independent of the gate-level structure.
    function automatic logic [W:0] refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic nanA, nanB, zA, zB, snA, snB, un, inv;
        longint magA, magB, ka, kb, ta, tb;
        logic [W-1:0] r;
        nanA = (a[31:29] == 3'b111);
        nanB = (b[31:29] == 3'b111);
        zA   = (a[31:29] == 3'b000);
        zB   = (b[31:29] == 3'b000);
        snA  = nanA && !a[22];
        snB  = nanB && !b[22];
        un   = nanA || nanB;
        magA = zA ? 64'sd0 : longint'({32'd0, a[31:0]});
        magB = zB ? 64'sd0 : longint'({32'd0, b[31:0]});
        ka   = a[32] ? -magA : magA;
        kb   = b[32] ? -magB : magB;
        ta   = a[32] ? -(2 * magA + 1) : 2 * magA;
        tb   = b[32] ? -(2 * magB + 1) : 2 * magB;
        r    = '0;
        inv  = 1'b0;
        case (op)
            OP_EQ:    begin r[0] = !un && (ka == kb); inv = snA || snB; end
            OP_LT:    begin r[0] = !un && (ka < kb);  inv = un; end
            OP_LE:    begin r[0] = !un && (ka <= kb); inv = un; end
            OP_UNORD: begin r[0] = un;                inv = snA || snB; end
            OP_MIN, OP_MAX: begin
                inv = snA || snB;
                if (nanA && nanB)      r = CANON;
                else if (nanA)         r = b;
                else if (nanB)         r = a;
                else if (op == OP_MIN) r = (tb < ta) ? b : a;
                else                   r = (ta < tb) ? b : a;
            end
            default: begin r = '0; inv = 1'b1; end
        endcase
        return {inv, r};
    endfunction

    function automatic logic [W-1:0] randOperand();
        logic [W-1:0] v;
        int cls;
        v[31:0] = $urandom;
        v[32]   = 1'($urandom_range(0, 1));
        cls     = $urandom_range(0, 5);
        case (cls)
            0:       v[31:29] = 3'b000;
            1:       v[31:29] = 3'b111;
            default: v[31:29] = 3'($urandom_range(1, 6));
        endcase
        return v;
    endfunction

    task automatic pushExpected(input logic [W-1:0] res, input logic inv, input logic [TW-1:0] tag);
        ExpEntry e;
        e.res   = res;
        e.flags = {inv, 4'b0000};
        e.tag   = tag;
        sbQueue.push_back(e);
    endtask

    // Offer one operation until accepted (bounded), recording its expected result.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag, input logic [W-1:0] expRes, input logic expInv);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 20 && !accepted; i++) begin
            #1;
            if (in_ready) begin
                pushExpected(expRes, expInv, tag);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("accept", accepted, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sbQueue.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_empty", sbQueue.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pop on handshake, hold stability and sticky-flag model.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            accExp   = 5'b00000;
            prevHeld = 1'b0;
        end else begin
            checkOutput("flags_acc", flags_acc, accExp);
            if (prevHeld) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_result", out_result, prevRes);
                checkOutput("hold_flags", out_flags, prevFlags);
                checkOutput("hold_tag", out_tag, prevTag);
            end
            hsFlags = 5'b00000;
            if (out_valid && out_ready) begin
                hsCycles.push_back(cyc);
                checkOutput("sb_nonempty", sbQueue.size() != 0, 1);
                if (sbQueue.size() != 0) begin
                    popped = sbQueue.pop_front();
                    checkOutput("result", out_result, popped.res);
                    checkOutput("flags", out_flags, popped.flags);
                    checkOutput("tag", out_tag, popped.tag);
                    hsFlags = popped.flags;
                end
            end
            accExp    = flags_clear ? hsFlags : (accExp | hsFlags);
            prevHeld  = out_valid && !out_ready;
            prevRes   = out_result;
            prevFlags = out_flags;
            prevTag   = out_tag;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] a, b;
        logic [W:0]   m;
        logic [2:0]   op;
        logic [2:0]   stallOps [4];
        logic [W-1:0] stallA [4];
        logic [W-1:0] stallB [4];
        int           idx;
        int           base;
        logic         seen;

        reset_n     = 1'b1;
        in_valid    = 1'b0;
        in_op       = '0;
        in_a        = '0;
        in_b        = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        flags_clear = 1'b0;

        // Reset state.
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_flags", out_flags, 0);
        checkOutput("rst_out_tag", out_tag, 0);
        checkOutput("rst_flags_acc", flags_acc, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Zeros compare equal; result visible after the second rising edge counting the accepting one.
        applyStimulus(OP_EQ, POS_ZERO, NEG_ZERO, 5'd1, 33'd1, 1'b0);
        @(negedge clk);
        checkOutput("latency_early", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_due", out_valid, 1);
        @(posedge clk);
        #1;

        // Directed operations issued back to back.
        applyStimulus(OP_LT,    POS_ZERO, NEG_ZERO, 5'd2,  33'd0,    1'b0);
        applyStimulus(OP_LT,    QNAN,     ONE,      5'd3,  33'd0,    1'b1);
        applyStimulus(OP_EQ,    QNAN,     ONE,      5'd4,  33'd0,    1'b0);
        applyStimulus(OP_EQ,    ONE,      SNAN,     5'd5,  33'd0,    1'b1);
        applyStimulus(OP_MIN,   NEG_ZERO, POS_ZERO, 5'd6,  NEG_ZERO, 1'b0);
        applyStimulus(OP_MAX,   NEG_ZERO, POS_ZERO, 5'd7,  POS_ZERO, 1'b0);
        applyStimulus(OP_MIN,   QNAN,     TWO,      5'd8,  TWO,      1'b0);
        applyStimulus(OP_MAX,   SNAN_NEG, SNAN,     5'd9,  CANON,    1'b1);
        applyStimulus(OP_LT,    NEG_TWO,  NEG_ONE,  5'd10, 33'd1,    1'b0);
        applyStimulus(OP_LE,    ONE,      ONE,      5'd11, 33'd1,    1'b0);
        applyStimulus(OP_UNORD, ONE,      QNAN,     5'd12, 33'd1,    1'b0);
        applyStimulus(OP_UNORD, SNAN,     ONE,      5'd13, 33'd1,    1'b1);
        applyStimulus(3'd6,     ONE,      TWO,      5'd14, 33'd0,    1'b1);
        applyStimulus(OP_MAX,   NEG_ONE,  TWO,      5'd15, TWO,      1'b0);
        applyStimulus(OP_MIN,   ONE,      NEG_TWO,  5'd16, NEG_TWO,  1'b0);
        applyStimulus(OP_LT,    ONE,      TWO,      5'd17, 33'd1,    1'b0);
        applyStimulus(OP_LE,    TWO,      ONE,      5'd18, 33'd0,    1'b0);
        drain();

        // Eight random operations with in_valid held high; results must come out on consecutive cycles.
        base = hsCycles.size();
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = randOperand();
            b  = (i % 3 == 0) ? {~a[32], a[31:0]} : randOperand();
            m  = refModel(op, a, b);
            in_valid = 1'b1;
            in_op    = op;
            in_a     = a;
            in_b     = b;
            in_tag   = TW'(i + 8);
            #1;
            checkOutput("b2b_in_ready", in_ready, 1);
            if (in_ready) pushExpected(m[W-1:0], m[W], TW'(i + 8));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        checkOutput("b2b_count", hsCycles.size() - base, 8);
        for (int k = 1; k < 8 && base + k < hsCycles.size(); k++) begin
            checkOutput("b2b_consecutive", hsCycles[base + k] - hsCycles[base + k - 1], 1);
        end

        // Consumer stall: only two operations fit, outputs hold, nothing lost after release.
        stallOps = '{OP_LT, OP_MAX, OP_EQ, OP_MIN};
        stallA   = '{ONE, NEG_ONE, TWO, QNAN};
        stallB   = '{TWO, NEG_TWO, TWO, NEG_ONE};
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 25 && idx < 4; c++) begin
            if (c == 5) begin
                checkOutput("stall_accepted", idx, 2);
                checkOutput("stall_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
            m = refModel(stallOps[idx], stallA[idx], stallB[idx]);
            in_valid = 1'b1;
            in_op    = stallOps[idx];
            in_a     = stallA[idx];
            in_b     = stallB[idx];
            in_tag   = TW'(idx + 20);
            #1;
            if (in_ready) begin
                pushExpected(m[W-1:0], m[W], TW'(idx + 20));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stall_all_accepted", idx, 4);
        drain();

        // Sticky flags with a clear alone, then a clear coinciding with an invalid handshake.
        flags_clear = 1'b1;
        @(posedge clk);
        #1 flags_clear = 1'b0;
        checkOutput("acc_clear_alone_1", flags_acc, 0);
        applyStimulus(OP_LT, QNAN, ONE, 5'd25, 33'd0, 1'b1);
        drain();
        checkOutput("acc_after_nan_lt", flags_acc, 5'h10);
        applyStimulus(OP_LT, ONE, SNAN, 5'd26, 33'd0, 1'b1);
        seen = out_valid;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = out_valid;
        end
        checkOutput("clr_hs_seen", seen, 1);
        flags_clear = 1'b1;
        @(posedge clk);
        #1 flags_clear = 1'b0;
        checkOutput("acc_clear_with_hs", flags_acc, 5'h10);
        drain();
        flags_clear = 1'b1;
        @(posedge clk);
        #1 flags_clear = 1'b0;
        checkOutput("acc_clear_alone_2", flags_acc, 0);

        // Reset with two operations in flight.
        applyStimulus(3'd7, ONE, TWO, 5'd27, 33'd0, 1'b1);
        drain();
        applyStimulus(OP_EQ, ONE, ONE, 5'd28, 33'd1, 1'b0);
        applyStimulus(OP_LT, ONE, TWO, 5'd29, 33'd1, 1'b0);
        checkOutput("pre_rst_acc", flags_acc, 5'h10);
        checkOutput("pre_rst_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_flags_acc", flags_acc, 0);
        checkOutput("mid_rst_out_result", out_result, 0);
        checkOutput("mid_rst_out_tag", out_tag, 0);
        sbQueue.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        checkOutput("rel_in_ready", in_ready, 1);
        applyStimulus(OP_MAX, ONE, TWO, 5'd30, TWO, 1'b0);
        @(negedge clk);
        checkOutput("rel_latency_early", out_valid, 0);
        @(negedge clk);
        checkOutput("rel_latency_due", out_valid, 1);
        @(posedge clk);
        #1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
